// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data unified-memory arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } arb_owner_e;

  typedef struct packed {
    u32_t   addr;
    u32_t   wrdata;
    wrstb_t wrstb;
  } mem_req_t;

  // Wide enough for the largest legal I_STARVE_MAX (15).
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating wait-cycle counters for the fetch and data ports.
// Only compiled when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wait,
  input  logic              d_wait,
  output logic [PERF_W-1:0] perf_i_wait,
  output logic [PERF_W-1:0] perf_d_wait
);

  // Counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_wait <= '0;
      perf_d_wait <= '0;
    end else begin
      if (i_wait && (perf_i_wait != '1)) perf_i_wait <= perf_i_wait + 1'b1;
      if (d_wait && (perf_d_wait != '1)) perf_d_wait <= perf_d_wait + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, one transaction at a time.
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int I_STARVE_MAX = 4,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wrdata,
  input  logic [3:0]        d_wrstb,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              m_req,
  output logic [31:0]       m_addr,
  output logic [31:0]       m_wrdata,
  output logic [3:0]        m_wrstb,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  output logic              busy,
  output logic [PERF_W-1:0] perf_i_wait,
  output logic [PERF_W-1:0] perf_d_wait
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(I_STARVE_MAX);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  mem_req_t            req_q, req_d;
  logic                m_req_q, m_req_d;
  logic                pick_data;

  // Data wins unless fetch has already been passed over I_STARVE_MAX times in a row.
  assign pick_data = d_req && (!i_req || (starve_q < STARVE_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_DATA;
      starve_q <= '0;
      req_q    <= '0;
      m_req_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      req_q    <= req_d;
      m_req_q  <= m_req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    req_d    = req_q;
    m_req_d  = m_req_q;
    i_valid  = 1'b0;
    d_valid  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_data) begin
          owner_d = OWN_DATA;
          req_d   = '{addr: d_addr, wrdata: d_wrdata, wrstb: d_wrstb};
          m_req_d = 1'b1;
          state_d = ARB_REQ;
          if (i_req) begin
            starve_d = (starve_q < STARVE_LIM) ? starve_q + 1'b1 : starve_q;
          end else begin
            starve_d = '0;
          end
        end else if (i_req) begin
          owner_d  = OWN_INST;
          req_d    = '{addr: i_addr, wrdata: '0, wrstb: '0};
          m_req_d  = 1'b1;
          state_d  = ARB_REQ;
          starve_d = '0;
        end
      end

      ARB_REQ: begin
        if (m_gnt) begin
          m_req_d = 1'b0;
          state_d = ARB_RESP;
        end
      end

      ARB_RESP: begin
        if (m_rvalid) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_INST) i_valid = 1'b1;
          else                     d_valid = 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  assign m_req    = m_req_q;
  assign m_addr   = req_q.addr;
  assign m_wrdata = req_q.wrdata;
  assign m_wrstb  = req_q.wrstb;
  assign busy     = (state_q != ARB_IDLE);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wait      (i_req & ~i_valid),
    .d_wait      (d_req & ~d_valid),
    .perf_i_wait (perf_i_wait),
    .perf_d_wait (perf_d_wait)
  );
`else
  assign perf_i_wait = '0;
  assign perf_d_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random requesters, a behavioural memory and an arbitration model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE = 4;
  localparam int PW     = 32;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, i_valid, d_req, d_valid;
  logic [31:0]   i_addr, i_rdata, d_addr, d_wrdata, d_rdata;
  logic [3:0]    d_wrstb, m_wrstb;
  logic          m_req, m_gnt, m_rvalid, busy;
  logic [31:0]   m_addr, m_wrdata, m_rdata;
  logic [PW-1:0] perf_i_wait, perf_d_wait;

  mem_arbiter #(.I_STARVE_MAX(STARVE), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wrdata(d_wrdata), .d_wrstb(d_wrstb),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wrdata(m_wrdata), .m_wrstb(m_wrstb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
  );

  initial forever #5 clk = ~clk;

  mem_req_t i_stim_q[$], d_stim_q[$], i_pay_q[$], d_pay_q[$];
  exp_t     i_exp_q[$], d_exp_q[$];
  bit       own_q[$];
  bit       grant_log[$];

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          i_busy = 0, d_busy = 0, i_got = 0, d_got = 0;
  int          i_issue_cyc = 0, i_valid_cyc = 0;
  int          gnt_dly = 0, rv_dly = 0, i_idle = 0, d_idle = 0;
  bit          rand_dly = 0, spurious = 0, fixed_en = 0, real_rv = 0;
  logic [31:0] fixed_data = 32'h0;
  int          perf_i_model = 0, perf_d_model = 0;

  function automatic logic [31:0] memHash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportEvent(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: actual %s, required none", name, what);
  endtask

  task automatic applyStimulus(input bit port_d, input logic [31:0] addr,
                               input logic [31:0] wrdata, input logic [3:0] wrstb);
    if (port_d) d_stim_q.push_back('{addr: addr, wrdata: wrdata, wrstb: wrstb});
    else        i_stim_q.push_back('{addr: addr, wrdata: 32'h0, wrstb: 4'h0});
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    i_stim_q.delete(); d_stim_q.delete(); i_pay_q.delete(); d_pay_q.delete();
    i_exp_q.delete(); d_exp_q.delete(); own_q.delete();
    i_got = 0;
    d_got = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    while ((i_stim_q.size() != 0 || d_stim_q.size() != 0 || i_busy || d_busy ||
            own_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) reportEvent("drain", "timeout");
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Fetch requester: holds i_req/i_addr until i_valid, may re-request back-to-back.
  initial begin : fetch_driver
    mem_req_t it;
    int       wcnt;
    i_req = 1'b0; i_addr = 32'h0; wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        i_req = 1'b0; i_busy = 0;
      end else begin
        if (i_busy) begin
          if (i_got) begin
            i_got = 0; i_busy = 0; i_req = 1'b0;
          end else begin
            wcnt++;
            if (wcnt > 200) begin
              reportEvent("i_timeout", "no i_valid");
              i_busy = 0; i_req = 1'b0;
            end
          end
        end
        if (!i_busy && i_stim_q.size() != 0 && $urandom_range(0, i_idle) == 0) begin
          it = i_stim_q.pop_front();
          i_addr = it.addr; i_req = 1'b1; i_busy = 1; wcnt = 0; i_issue_cyc = cyc;
          i_pay_q.push_back('{addr: it.addr, wrdata: 32'h0, wrstb: 4'h0});
          i_exp_q.push_back('{chk: 1'b1, data: fixed_en ? fixed_data : memHash(it.addr)});
        end
      end
    end
  end

  // Data requester: loads and stores, same handshake as fetch.
  initial begin : data_driver
    mem_req_t it;
    int       wcnt;
    d_req = 1'b0; d_addr = 32'h0; d_wrdata = 32'h0; d_wrstb = 4'h0; wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        d_req = 1'b0; d_busy = 0;
      end else begin
        if (d_busy) begin
          if (d_got) begin
            d_got = 0; d_busy = 0; d_req = 1'b0;
          end else begin
            wcnt++;
            if (wcnt > 200) begin
              reportEvent("d_timeout", "no d_valid");
              d_busy = 0; d_req = 1'b0;
            end
          end
        end
        if (!d_busy && d_stim_q.size() != 0 && $urandom_range(0, d_idle) == 0) begin
          it = d_stim_q.pop_front();
          d_addr = it.addr; d_wrdata = it.wrdata; d_wrstb = it.wrstb;
          d_req = 1'b1; d_busy = 1; wcnt = 0;
          d_pay_q.push_back(it);
          d_exp_q.push_back('{chk: (it.wrstb == 4'h0),
                              data: fixed_en ? fixed_data : memHash(it.addr)});
        end
      end
    end
  end

  // Behavioural memory: configurable grant/response delays plus stray gnt/rvalid pulses.
  initial begin : memory_model
    int          cnt;
    bit          ph;
    logic [31:0] cap;
    cnt = 0; ph = 0; cap = 32'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; real_rv = 0;
      if (!ph) begin
        if (m_req) begin
          if (cnt >= gnt_dly) begin
            m_gnt = 1'b1; cap = m_addr; ph = 1; cnt = 0;
            if (rand_dly) rv_dly = $urandom_range(0, 3);
          end else begin
            if (spurious && cnt == 1) begin
              m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
            end
            cnt++;
          end
        end else begin
          cnt = 0;
          if (rand_dly && $urandom_range(0, 3) == 0) begin
            m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD1_BAD1;
          end
        end
      end else begin
        if (rand_dly) m_gnt = ($urandom_range(0, 2) == 0);
        if (cnt >= rv_dly) begin
          m_rvalid = 1'b1; real_rv = 1; ph = 0; cnt = 0;
          m_rdata = fixed_en ? fixed_data : memHash(cap);
          if (rand_dly) gnt_dly = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: predicts each grant's owner from the pending requests, checks payload and responses.
  initial begin : monitor
    bit       prev_m_req, prev_i, prev_d, want_data, got_data;
    int       streak;
    mem_req_t held, p;
    exp_t     e;
    prev_m_req = 0; prev_i = 0; prev_d = 0; streak = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_m_req = 0; prev_i = 0; prev_d = 0; streak = 0;
        perf_i_model = 0; perf_d_model = 0;
      end else begin
        if (i_req && !i_valid) perf_i_model++;
        if (d_req && !d_valid) perf_d_model++;
        if (m_req && !prev_m_req) begin
          want_data = prev_d && (!prev_i || streak < STARVE);
          streak = (want_data && prev_i) ? streak + 1 : 0;
          if (want_data ? (d_pay_q.size() == 0) : (i_pay_q.size() == 0)) begin
            reportEvent("grant", "request with no pending requester");
          end else begin
            p = want_data ? d_pay_q.pop_front() : i_pay_q.pop_front();
            checkOutput("m_addr", m_addr, p.addr);
            checkOutput("m_wrdata", m_wrdata, p.wrdata);
            checkOutput("m_wrstb", 32'(m_wrstb), 32'(p.wrstb));
          end
          own_q.push_back(want_data);
        end else if (m_req) begin
          checkOutput("m_addr_hold", m_addr, held.addr);
          checkOutput("m_wrdata_hold", m_wrdata, held.wrdata);
          checkOutput("m_wrstb_hold", 32'(m_wrstb), 32'(held.wrstb));
        end
        checkOutput("busy", 32'(busy), 32'(own_q.size() != 0));
        if (i_valid || d_valid) begin
          checkOutput("valid_on_real_rvalid", 32'(real_rv), 32'd1);
          if (own_q.size() == 0) begin
            reportEvent("valid", "response with nothing outstanding");
          end else begin
            got_data = own_q.pop_front();
            checkOutput("valid_port", 32'({i_valid, d_valid}), got_data ? 32'd1 : 32'd2);
            grant_log.push_back(d_valid);
          end
          if (i_valid) begin
            if (i_exp_q.size() != 0) begin
              e = i_exp_q.pop_front();
              checkOutput("i_rdata", i_rdata, e.data);
            end
            i_got = 1; i_valid_cyc = cyc;
          end
          if (d_valid) begin
            if (d_exp_q.size() != 0) begin
              e = d_exp_q.pop_front();
              if (e.chk) checkOutput("d_rdata", d_rdata, e.data);
            end
            d_got = 1;
          end
        end
        held = '{addr: m_addr, wrdata: m_wrdata, wrstb: m_wrstb};
        prev_m_req = m_req; prev_i = i_req; prev_d = d_req;
      end
    end
  end

  initial begin : main
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_req", 32'(m_req), 32'd0);
    checkOutput("rst_m_addr", m_addr, 32'd0);
    checkOutput("rst_m_wrdata", m_wrdata, 32'd0);
    checkOutput("rst_m_wrstb", 32'(m_wrstb), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_perf_i", perf_i_wait, 32'd0);
    checkOutput("rst_perf_d", perf_d_wait, 32'd0);
    rst_n = 1'b1;

    $display("[TB] single fetch");
    fixed_en = 1; fixed_data = 32'hDEAD_BEEF; gnt_dly = 0; rv_dly = 0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0);
    waitDrain(100);
    checkOutput("fetch_latency", 32'(i_valid_cyc - i_issue_cyc), 32'd2);

    $display("[TB] store");
    @(negedge clk);
    applyStimulus(1'b1, 32'h200, 32'h1234_5678, 4'b0011);
    waitDrain(100);

    $display("[TB] contention");
    applyReset();
    fixed_en = 0; i_idle = 0; d_idle = 0;
    grant_log.delete();
    @(negedge clk);
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++)  applyStimulus(1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0);
    waitDrain(1000);
    checkOutput("grant_count", 32'(grant_log.size()), 32'd15);
    for (int k = 0; k < 15 && k < grant_log.size(); k++)
      checkOutput($sformatf("grant_%0d", k), 32'(grant_log[k]), 32'((k % 5) != 4));

    $display("[TB] slow memory with stray rvalid");
    applyReset();
    fixed_en = 1; fixed_data = 32'hCAFE_F00D; gnt_dly = 3; rv_dly = 5; spurious = 1;
    @(negedge clk);
    applyStimulus(1'b0, 32'h340, 32'h0, 4'h0);
    waitDrain(100);
    checkOutput("slow_latency", 32'(i_valid_cyc - i_issue_cyc), 32'd10);
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_i_stall", perf_i_wait, 32'd10);
`else
    checkOutput("perf_i_stall", perf_i_wait, 32'd0);
`endif
    spurious = 0;

    $display("[TB] reset while waiting for response");
    fixed_en = 0; gnt_dly = 0; rv_dly = 8;
    @(negedge clk);
    applyStimulus(1'b1, 32'h400, 32'h0, 4'h0);
    begin : wait_resp
      int k;
      k = 0;
      while (!(busy && !m_req && own_q.size() != 0) && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) reportEvent("resp_wait", "timeout");
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_req", 32'(m_req), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    applyReset();
    repeat (12) @(posedge clk);

    $display("[TB] random traffic");
    applyReset();
    rand_dly = 1; spurious = 1; i_idle = 3; d_idle = 3;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0);
      applyStimulus(1'b1, $urandom & 32'hFFFF_FFFC, $urandom,
                    ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
    end
    waitDrain(5000);
    repeat (2) @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_i_wait", perf_i_wait, 32'(perf_i_model));
    checkOutput("perf_d_wait", perf_d_wait, 32'(perf_d_model));
`else
    checkOutput("perf_i_wait", perf_i_wait, 32'd0);
    checkOutput("perf_d_wait", perf_d_wait, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and data-memory port.
- Sits between the core's IMEM/DMEM interfaces and the external memory.
- Allows one outstanding transaction at a time, with a req/gnt request phase and an rvalid response phase.
- Data has priority because it belongs to the older instruction. A starvation counter bounds how long fetch can be delayed.

Parameters:
- I_STARVE_MAX, 4: number of consecutive data grants, with i_req pending, after which the next arbitration goes to fetch. Legal range 1..15.
- PERF_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_valid
- i_addr  in  32  fetch word address
- i_valid  out  1  fetch response pulse
- i_rdata  out  32  fetch data, qualified by i_valid
- d_req  in  1  data request; held with payload until d_valid
- d_addr  in  32  data address
- d_wrdata  in  32  store data
- d_wrstb  in  4  byte strobes; 0 = load, nonzero = store
- d_valid  out  1  data response or store acknowledge pulse
- d_rdata  out  32  load data, qualified by d_valid
- m_req  out  1  memory request
- m_addr  out  32  memory address
- m_wrdata  out  32  memory write data
- m_wrstb  out  4  memory byte strobes
- m_gnt  in  1  memory accepts the request this cycle
- m_rvalid  in  1  memory response (load data or store ack)
- m_rdata  in  32  memory read data
- busy  out  1  high when the FSM is not IDLE
- perf_i_wait  out  PERF_W  fetch wait cycles (optional feature)
- perf_d_wait  out  PERF_W  data wait cycles (optional feature)

Behaviour:
- Reset:
  - FSM goes to IDLE; owner = DATA.
  - Starvation counter cleared; perf counters cleared.
  - m_req, m_addr, m_wrdata, m_wrstb, busy and both perf counters are 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If d_req and (i_req = 0 or starve_cnt < I_STARVE_MAX): owner = DATA.
  - Else if i_req: owner = INST.
  - On a decision, latch the owner's addr/wrdata/wrstb into the m_* registers (fetch forces wrstb = 0), set m_req = 1, go to REQ.
  - No request: stay in IDLE.
- Starvation counter:
  - Incremented on a DATA grant while i_req = 1.
  - Cleared on an INST grant, or on a DATA grant with i_req = 0.
  - Saturates at I_STARVE_MAX.
- REQ:
  - m_req and the payload are held stable.
  - On m_gnt: m_req <= 0, go to RESP.
- RESP:
  - On m_rvalid, combinationally: owner_valid = 1 and owner_rdata = m_rdata in the same cycle; next state IDLE.
  - rdata outputs pass m_rdata through and are don't-care when their valid is low.
- Latency: best case is request at cycle 0, m_req at cycle 1, m_gnt at cycle 1, m_rvalid/valid at cycle 2. Minimum 2 cycles from req to valid.
- Back-to-back: the requester may keep req high after valid with a new payload. It is re-arbitrated in IDLE on the following cycle (one idle bubble per transaction).
- Ignored inputs:
  - m_gnt outside REQ.
  - m_rvalid outside RESP.
- Requests that change or drop before valid are protocol violations; behaviour is undefined, but the FSM never deadlocks.
- Reset asserted mid-transaction: immediate return to IDLE, m_req drops asynchronously, and the outstanding response is discarded. A later m_rvalid is ignored per the rule above.
- Simultaneous i_req and d_req with starve_cnt = I_STARVE_MAX: INST wins and the counter is cleared.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - perf_i_wait increments every cycle with i_req = 1 and i_valid = 0.
  - perf_d_wait increments likewise for the data port.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: perf_i_wait and perf_d_wait are tied to 0 and no counter logic is built. The port list is unchanged.

Decomposition:
- Add to the types package:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_RESP}
  - arb_owner_e {OWN_INST, OWN_DATA}
  - mem_req_t struct {u32_t addr; u32_t wrdata; wrstb_t wrstb}
- Reuse u32_t and wrstb_t.
- One sub-module: mem_arb_perf, holding the two saturating counters and instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Single fetch: i_req with i_addr = 0x100; memory gnt at once, rvalid next cycle, m_rdata = 0xDEADBEEF. Expect m_req with m_addr = 0x100 and m_wrstb = 0, then i_valid = 1 with i_rdata = 0xDEADBEEF exactly 2 cycles after i_req.
- Store: d_req with d_addr = 0x200, d_wrdata = 0x12345678, d_wrstb = 4'b0011. Expect m_wrstb = 4'b0011 and m_wrdata = 0x12345678, then d_valid on ack.
- Contention: i_req and d_req held continuously with I_STARVE_MAX = 4. Expect grant order D,D,D,D,I repeating.
- Slow memory: gnt delayed 3 cycles, rvalid delayed 5 cycles. Expect m_req and payload stable throughout and busy = 1. Spurious rvalid during REQ is ignored.
- Reset mid-RESP: assert rst_n = 0 while waiting for rvalid. Expect m_req = 0 and busy = 0 immediately. A late rvalid produces no i_valid or d_valid.
- With MEM_ARB_PERF_EN: 10-cycle fetch stall gives perf_i_wait = 10. Without the macro, perf_i_wait reads 0.
